// File: rtl/imem_fetch_sequencer_if.sv
// rtl/imem_fetch_sequencer_if.sv - loader handshake and instruction-memory bus of the fetch sequencer
interface imem_fetch_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              imem_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_rdata;

  modport master (
    input  ld_valid, ld_data, ld_last,
    output ld_ready,
    output imem_en, imem_we, imem_addr, imem_wdata,
    input  imem_rdata
  );

  modport slave (
    output ld_valid, ld_data, ld_last,
    input  ld_ready,
    input  imem_en, imem_we, imem_addr, imem_wdata,
    output imem_rdata
  );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// rtl/imem_fetch_sequencer.sv - loads instruction memory from a boot stream, then fetches with stall/branch handling
module imem_fetch_sequencer #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_fetch_sequencer_if.master bus,
  input  logic        reload,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        busy
);
  localparam logic [0:0]        S_LOAD    = 1'b0;
  localparam logic [0:0]        S_RUN     = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [31:0]       pc;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic              fresh;
  logic [31:0]       held_instr;
  logic              run;
  logic              issue;
  logic [31:0]       target;

  assign run    = (state == S_RUN);
  assign issue  = run & ~reload & ~br_taken & ~stall;
  assign target = (br_pc & 32'hFFFF_FFFC) + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};

  assign bus.ld_ready   = ~run;
  assign busy           = ~run;
  assign bus.imem_en    = run ? issue : bus.ld_valid;
  assign bus.imem_we    = ~run & bus.ld_valid;
  assign bus.imem_addr  = run ? pc[ADDR_W+1:2] : ld_ptr;
  assign bus.imem_wdata = bus.ld_data;

  // fresh: the read issued last cycle lands on imem_rdata now; otherwise replay the captured word
  assign if_valid = out_valid;
  assign if_pc    = out_pc;
  assign if_instr = !out_valid ? NOP_WORD : (fresh ? bus.imem_rdata : held_instr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      ld_ptr     <= '0;
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_pc     <= 32'h0;
      fresh      <= 1'b0;
      held_instr <= NOP_WORD;
    end else begin
      if (fresh) held_instr <= bus.imem_rdata;
      if (state == S_LOAD) begin
        out_valid <= 1'b0;
        fresh     <= 1'b0;
        if (bus.ld_valid) begin
          ld_ptr <= ld_ptr + 1'b1;
          if (bus.ld_last || ld_ptr == LAST_ADDR) begin
            state <= S_RUN;
            pc    <= RESET_PC;
          end
        end
      end else if (reload) begin
        state     <= S_LOAD;
        ld_ptr    <= '0;
        out_valid <= 1'b0;
        fresh     <= 1'b0;
      end else if (br_taken) begin
        pc        <= target;
        out_valid <= 1'b0;
        fresh     <= 1'b0;
      end else if (stall) begin
        fresh <= 1'b0;
      end else begin
        pc        <= pc + 32'd4;
        out_valid <= 1'b1;
        out_pc    <= pc;
        fresh     <= 1'b1;
      end
    end
  end
endmodule
